// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with a byte FIFO and fixed-divider baud timing.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wr_i,
    input  logic [7:0]                        wdata_i,
    output logic                              full_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              busy_o,
    output logic                              ovf_o,
    output logic                              tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [15:0] LOAD = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [15:0]   baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          push, pop, tick, line;
    logic [CW-1:0] count_next;

    assign tick = baud == 16'd0;
    assign push = wr_i && !full_o;
    assign pop  = count_o != '0 && (state == IDLE || (state == STOP && tick));

    always_comb begin
        count_next = count_o + CW'(push) - CW'(pop);
        line = state == START ? 1'b0 : state == DATA ? shift[bit_idx] : 1'b1;
    end

    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= wdata_i;

    // tx_o and busy_o are registered copies of the current state, one cycle behind it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
            full_o  <= 1'b0;
            ovf_o   <= 1'b0;
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shift  <= mem[rd_ptr];
            end
            count_o <= count_next;
            full_o  <= count_next == FULL;
            ovf_o   <= ovf_o | (wr_i && full_o);
            tx_o    <= line;
            busy_o  <= state != IDLE;
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    baud  <= LOAD;
                end
                START: if (tick) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    baud    <= LOAD;
                end else baud <= baud - 16'd1;
                DATA: if (tick) begin
                    bit_idx <= bit_idx + 3'd1;
                    baud    <= LOAD;
                    if (bit_idx == 3'd7) state <= STOP;
                end else baud <= baud - 16'd1;
                STOP: if (tick) begin
                    state <= pop ? START : IDLE;
                    baud  <= LOAD;
                end else baud <= baud - 16'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks the transmitter against a frame-timeline reference model plus directed scenarios.
module tb_uart_tx_fifo;
    localparam int B  = 4;
    localparam int D  = 16;
    localparam int FL = 10 * B;

    logic       clk_i = 1'b0, rst_i = 1'b1, wr_i = 1'b0;
    logic [7:0] wdata_i = '0;
    logic       full_o, busy_o, ovf_o, tx_o;
    logic [4:0] count_o;

    uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_i(wr_i), .wdata_i(wdata_i),
        .full_o(full_o), .count_o(count_o), .busy_o(busy_o), .ovf_o(ovf_o), .tx_o(tx_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0, errors = 0, cyc = 0;
    logic [7:0] q[$];
    logic [7:0] cur;
    bit in_frame = 0, m_ovf = 0, e_tx = 1, e_busy = 0;
    int t = 0;
    logic tx_hist [20000];
    logic busy_hist [20000];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // slot 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit
    function automatic bit frame_bit(input logic [7:0] b, input int k);
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    endfunction

    // t counts cycles since the byte left the queue; tx shows the frame one cycle later
    task automatic model(input bit r, input bit w, input logic [7:0] d);
        bit pop, acc;
        if (r) begin
            q.delete(); in_frame = 0; t = 0; m_ovf = 0; e_tx = 1; e_busy = 0;
            return;
        end
        e_tx   = in_frame ? frame_bit(cur, t / B) : 1'b1;
        e_busy = in_frame;
        pop = q.size() > 0 && (!in_frame || t == FL - 1);
        acc = w && q.size() < D;
        if (w && q.size() == D) m_ovf = 1;
        if (pop) begin
            cur = q.pop_front(); in_frame = 1; t = 0;
        end else if (in_frame) begin
            if (t == FL - 1) in_frame = 0; else t++;
        end
        if (acc) q.push_back(d);
    endtask

    task automatic step(input bit r, input bit w, input logic [7:0] d);
        rst_i = r; wr_i = w; wdata_i = d;
        @(posedge clk_i);
        model(r, w, d);
        #1;
        cyc++;
        tx_hist[cyc] = tx_o;
        busy_hist[cyc] = busy_o;
        chk("tx", tx_o, e_tx);
        chk("count", count_o, q.size());
        chk("full", full_o, q.size() == D);
        chk("busy", busy_o, e_busy);
        chk("ovf", ovf_o, m_ovf);
    endtask

    task automatic check_frame(input string tag, input int n, input logic [7:0] b);
        for (int s = 0; s < 10; s++)
            for (int k = 0; k < B; k++)
                chk(tag, tx_hist[n + 2 + s * B + k], frame_bit(b, s));
    endtask

    task automatic drain();
        int g = 0;
        while ((in_frame || q.size() > 0) && g < 40 * FL) begin
            step(0, 0, 0); g++;
        end
        chk("drain_timeout", in_frame || q.size() > 0, 0);
        step(0, 0, 0);
    endtask

    initial begin
        int n, g;
        logic all;
        repeat (3) step(1, 0, 0);
        chk("rst_tx", tx_o, 1); chk("rst_full", full_o, 0); chk("rst_count", count_o, 0);
        chk("rst_busy", busy_o, 0); chk("rst_ovf", ovf_o, 0);
        repeat (100) step(0, 0, 0);
        all = 1;
        for (int i = cyc - 99; i <= cyc; i++) all &= tx_hist[i];
        chk("idle_tx", all, 1);

        step(0, 1, 8'hA5);
        n = cyc;
        repeat (50) step(0, 0, 0);
        check_frame("a5_frame", n, 8'hA5);
        chk("a5_busy41", busy_hist[n + 41], 1);
        chk("a5_busy42", busy_hist[n + 42], 0);
        chk("a5_line_after", tx_hist[n + 42], 1);

        step(0, 1, 8'h00); n = cyc;
        step(0, 1, 8'hFF);
        step(0, 1, 8'h55);
        chk("b2b_count", count_o, 2);
        repeat (3 * FL + 5) step(0, 0, 0);
        check_frame("b2b_f0", n, 8'h00);
        check_frame("b2b_f1", n + FL, 8'hFF);
        check_frame("b2b_f2", n + 2 * FL, 8'h55);
        all = 1;
        for (int i = n + 2; i < n + 2 + 3 * FL; i++) all &= busy_hist[i];
        chk("b2b_nogap", all, 1);
        drain();

        for (int k = 1; k <= 18; k++) begin
            step(0, 1, 8'(k));
            if (k == 16) chk("full_before17", full_o, 0);
            if (k == 17) begin
                chk("full_at17", full_o, 1);
                chk("count_at17", count_o, 16);
            end
        end
        chk("ovf_set", ovf_o, 1);

        for (int r = 0; r < 3; r++) begin
            g = 0;
            while (!(in_frame && t == FL - 1 && q.size() == 3) && g < 40 * FL) begin
                step(0, 0, 0); g++;
            end
            chk("pushpop_timeout", g < 40 * FL, 1);
            step(0, 1, 8'hC0 + 8'(r));
            chk("pushpop_count", count_o, 3);
        end
        chk("ovf_sticky", ovf_o, 1);

        g = 0;
        while (!(in_frame && t == 4 * B) && g < 4 * FL) begin
            step(0, 0, 0); g++;
        end
        chk("midframe_timeout", g < 4 * FL, 1);
        step(1, 0, 0);
        chk("mid_rst_tx", tx_o, 1); chk("mid_rst_count", count_o, 0);
        chk("mid_rst_ovf", ovf_o, 0); chk("mid_rst_full", full_o, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 8'h3C); n = cyc;
        repeat (50) step(0, 0, 0);
        check_frame("3c_frame", n, 8'h3C);

        for (int i = 0; i < 3000; i++) begin
            int rate;
            rate = (i / 500) % 2 ? 60 : 3;
            if ($urandom_range(0, 999) == 0) step(1, 0, 0);
            else step(0, $urandom_range(0, 99) < rate, 8'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
